// File: rtl/srk_pkg.sv
// Shared definitions for the bit-field sequencer: command codes, sequencer
// states and status bit positions.
package srk_pkg;

    localparam logic [2:0] SRK_CMD_NOP        = 3'd0;
    localparam logic [2:0] SRK_CMD_LD_POS     = 3'd1;
    localparam logic [2:0] SRK_CMD_LD_SIZ     = 3'd2;
    localparam logic [2:0] SRK_CMD_LD_POS_MSS = 3'd3;
    localparam logic [2:0] SRK_CMD_START      = 3'd4;
    localparam logic [2:0] SRK_CMD_ABORT      = 3'd5;
    localparam logic [2:0] SRK_CMD_RD_POS     = 3'd6;
    localparam logic [2:0] SRK_CMD_RD_SIZ     = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P0   = 2'd1,
        P1   = 2'd2
    } srk_state_e;

    localparam int STA_SPANS    = 0;
    localparam int STA_SIZ_ZERO = 1;
    localparam int STA_MSS_NONE = 2;

endpackage

// File: rtl/srk_field_seq_if.sv
// Pass descriptor handshake between the field sequencer and the rotator datapath.
interface srk_field_seq_if #(
    parameter int DW = 32,
    parameter int SW = $clog2(DW),
    parameter int PW = $clog2(DW) + 1
);
    logic          pass_vld_h;
    logic          pass_rdy_h;
    logic [SW-1:0] shf_h;
    logic [PW-1:0] mask_len_h;
    logic          pass_last_h;

    modport master (
        output pass_vld_h, shf_h, mask_len_h, pass_last_h,
        input  pass_rdy_h
    );

    modport slave (
        input  pass_vld_h, shf_h, mask_len_h, pass_last_h,
        output pass_rdy_h
    );
endinterface

// File: rtl/srk_mss_enc.sv
// Most-significant-set-bit priority encoder; none flags an all-zero input.
module srk_mss_enc #(
    parameter int DW = 32,
    parameter int SW = $clog2(DW)
) (
    input  logic [DW-1:0] data,
    output logic [SW-1:0] idx,
    output logic          none
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = 0; i < DW; i++) begin
            if (data[i]) begin
                idx  = SW'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/srk_field_seq.sv
// Field position/size registers and the one- or two-pass sequencer that feeds
// rotate counts and mask lengths to the datapath.
//
//   state | meaning
//   IDLE  | no pass outstanding; loads and START accepted
//   P0    | first (or only) pass presented
//   P1    | second pass of a word-spanning field presented
module srk_field_seq
    import srk_pkg::*;
#(
    parameter int DW = 32,
    parameter int SW = $clog2(DW),
    parameter int PW = $clog2(DW) + 1
) (
    input  logic          qd_clk_l,
    input  logic          rst_l,
    input  logic [2:0]    cmd_h,
    input  logic [DW-1:0] wbus_h,
    input  logic [DW-1:0] sbus_h,
    output logic [DW-1:0] sbus_out_h,
    srk_field_seq_if.master pass_if,
    output logic          busy_h,
    output logic [2:0]    sta_h,
    output logic          rsv_err_h
);

    localparam int            PW1     = PW + 1;
    localparam logic [PW-1:0] SIZ_MAX = PW'(DW);
    localparam logic [PW:0]   END_MAX = PW1'(DW);

    srk_state_e    r_state, w_state_nxt;
    logic [PW-1:0] r_pos, w_pos_nxt;
    logic [PW-1:0] r_siz, w_siz_nxt;
    logic [SW-1:0] r_shf, w_shf_nxt;
    logic [PW-1:0] r_mask, w_mask_nxt;
    logic          r_last, w_last_nxt;
    logic [2:0]    r_sta, w_sta_nxt;
    logic          r_rsv_err, w_rsv_err_nxt;

    logic [SW-1:0] w_off;
    logic [PW:0]   w_end;
    logic          w_spans;
    logic [PW-1:0] w_rem;
    logic [SW-1:0] w_mss_idx;
    logic          w_mss_none;
    logic          w_hs;
    logic          w_unused_wbus;

    srk_mss_enc #(.DW(DW), .SW(SW)) u_mss (
        .data (sbus_h),
        .idx  (w_mss_idx),
        .none (w_mss_none)
    );

    assign w_off         = r_pos[SW-1:0];
    assign w_end         = {2'b00, w_off} + {1'b0, r_siz};
    assign w_spans       = (w_end > END_MAX);
    // Bits left in the word from off upward; also the second pass's rotate count.
    assign w_rem         = SIZ_MAX - {1'b0, w_off};
    assign w_hs          = pass_if.pass_vld_h & pass_if.pass_rdy_h;
    assign w_unused_wbus = ^wbus_h[DW-1:PW];

    always_comb begin
        unique case (cmd_h)
            SRK_CMD_RD_POS: sbus_out_h = DW'(r_pos);
            SRK_CMD_RD_SIZ: sbus_out_h = DW'(r_siz);
            default:        sbus_out_h = '1;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pos_nxt     = r_pos;
        w_siz_nxt     = r_siz;
        w_shf_nxt     = r_shf;
        w_mask_nxt    = r_mask;
        w_last_nxt    = r_last;
        w_sta_nxt     = r_sta;
        w_rsv_err_nxt = r_rsv_err;
        unique case (r_state)
            IDLE: begin
                unique case (cmd_h)
                    SRK_CMD_LD_POS: w_pos_nxt = wbus_h[PW-1:0];
                    SRK_CMD_LD_SIZ: begin
                        w_siz_nxt     = wbus_h[PW-1:0];
                        w_rsv_err_nxt = 1'b0;
                    end
                    SRK_CMD_LD_POS_MSS: begin
                        w_pos_nxt               = {1'b0, w_mss_idx};
                        w_sta_nxt[STA_MSS_NONE] = w_mss_none;
                    end
                    SRK_CMD_START: begin
                        if (r_siz > SIZ_MAX) begin
                            w_rsv_err_nxt = 1'b1;
                        end else if (r_siz == '0) begin
                            w_sta_nxt[STA_SIZ_ZERO] = 1'b1;
                        end else begin
                            w_sta_nxt[STA_SIZ_ZERO] = 1'b0;
                            w_sta_nxt[STA_SPANS]    = w_spans;
                            w_state_nxt             = P0;
                            w_shf_nxt               = w_off;
                            w_mask_nxt              = w_spans ? w_rem : r_siz;
                            w_last_nxt              = ~w_spans;
                        end
                    end
                    default: ;
                endcase
            end
            P0: begin
                if (cmd_h == SRK_CMD_ABORT) begin
                    w_state_nxt = IDLE;
                end else if (w_hs) begin
                    if (w_spans) begin
                        w_state_nxt = P1;
                        w_shf_nxt   = w_rem[SW-1:0];
                        w_mask_nxt  = r_siz - w_rem;
                        w_last_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            P1: begin
                if (cmd_h == SRK_CMD_ABORT || w_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge qd_clk_l or negedge rst_l) begin
        if (!rst_l) begin
            r_state   <= IDLE;
            r_pos     <= '0;
            r_siz     <= '0;
            r_shf     <= '0;
            r_mask    <= '0;
            r_last    <= 1'b0;
            r_sta     <= '0;
            r_rsv_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pos     <= w_pos_nxt;
            r_siz     <= w_siz_nxt;
            r_shf     <= w_shf_nxt;
            r_mask    <= w_mask_nxt;
            r_last    <= w_last_nxt;
            r_sta     <= w_sta_nxt;
            r_rsv_err <= w_rsv_err_nxt;
        end
    end

    assign busy_h              = (r_state != IDLE);
    assign pass_if.pass_vld_h  = (r_state != IDLE);
    assign pass_if.shf_h       = r_shf;
    assign pass_if.mask_len_h  = r_mask;
    assign pass_if.pass_last_h = r_last;
    assign sta_h               = r_sta;
    assign rsv_err_h           = r_rsv_err;

endmodule

// File: tb/tb_srk_field_seq.sv
// Bench for srk_field_seq: a pass-queue model checked every cycle, plus
// hand-computed expectations for the key scenarios.
module tb_srk_field_seq;
    import srk_pkg::*;

    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [2:0]  cmd_h;
    logic [31:0] wbus_h, sbus_h, sbus_out_h;
    logic        busy_h, rsv_err_h;
    logic [2:0]  sta_h;

    srk_field_seq_if #(.DW(DW)) pif ();

    srk_field_seq #(.DW(DW)) dut (
        .qd_clk_l   (clk),
        .rst_l      (rst_l),
        .cmd_h      (cmd_h),
        .wbus_h     (wbus_h),
        .sbus_h     (sbus_h),
        .sbus_out_h (sbus_out_h),
        .pass_if    (pif.master),
        .busy_h     (busy_h),
        .sta_h      (sta_h),
        .rsv_err_h  (rsv_err_h)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: the sequence of passes a START produces, queued up front.
    typedef struct { int shf; int mask; int last; } pass_t;
    pass_t q[$];
    int    m_pos, m_siz, m_sta, m_rsv;

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            q.delete();
            m_pos = 0; m_siz = 0; m_sta = 0; m_rsv = 0;
        end else if (q.size() != 0) begin
            if (cmd_h == SRK_CMD_ABORT) q.delete();
            else if (pif.pass_rdy_h) void'(q.pop_front());
        end else begin
            case (cmd_h)
                SRK_CMD_LD_POS: m_pos = wbus_h % 64;
                SRK_CMD_LD_SIZ: begin m_siz = wbus_h % 64; m_rsv = 0; end
                SRK_CMD_LD_POS_MSS: begin
                    m_pos = 0;
                    for (int i = 0; i < DW; i++) if (sbus_h[i]) m_pos = i;
                    m_sta = (sbus_h == 0) ? (m_sta | 4) : (m_sta & 3);
                end
                SRK_CMD_START: begin
                    if (m_siz > DW) m_rsv = 1;
                    else if (m_siz == 0) m_sta = m_sta | 2;
                    else begin
                        int off, first;
                        off = m_pos % DW;
                        if (off + m_siz > DW) begin
                            first = DW - off;
                            q.push_back('{off, first, 0});
                            q.push_back('{first % DW, m_siz - first, 1});
                            m_sta = (m_sta & 4) | 1;
                        end else begin
                            q.push_back('{off, m_siz, 1});
                            m_sta = m_sta & 4;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_l) begin
            chk("vld", pif.pass_vld_h, q.size() != 0);
            chk("busy", busy_h, q.size() != 0);
            chk("sta", sta_h, m_sta);
            chk("rsv_err", rsv_err_h, m_rsv);
            if (q.size() != 0 && pif.pass_vld_h) begin
                chk("shf", pif.shf_h, q[0].shf);
                chk("mask_len", pif.mask_len_h, q[0].mask);
                chk("last", pif.pass_last_h, q[0].last);
            end
        end
    end

    task automatic step(input logic [2:0] c, input logic [31:0] w, input logic [31:0] s, input logic r);
        cmd_h = c; wbus_h = w; sbus_h = s; pif.pass_rdy_h = r;
        @(negedge clk);
    endtask

    task automatic rd(input string name, input logic [2:0] c, input logic [63:0] e);
        cmd_h = c; pif.pass_rdy_h = 1'b1;
        #1 chk(name, sbus_out_h, e);
        @(negedge clk);
    endtask

    task automatic load(input int p, input int s);
        step(SRK_CMD_LD_POS, p, 0, 1'b1);
        step(SRK_CMD_LD_SIZ, s, 0, 1'b1);
    endtask

    int tbl_pos[8] = '{0, 24, 31, 31, 1, 16, 40, 12};
    int tbl_siz[8] = '{32, 8, 1, 2, 32, 17, 30, 20};

    initial begin
        rst_l = 1'b0; cmd_h = SRK_CMD_NOP; wbus_h = 0; sbus_h = 0; pif.pass_rdy_h = 1'b0;
        #12;
        chk("rst_vld", pif.pass_vld_h, 0);
        chk("rst_shf", pif.shf_h, 0);
        chk("rst_mask", pif.mask_len_h, 0);
        chk("rst_last", pif.pass_last_h, 0);
        chk("rst_busy", busy_h, 0);
        chk("rst_sta", sta_h, 0);
        chk("rst_rsv", rsv_err_h, 0);
        @(negedge clk); #2 rst_l = 1'b1;
        @(negedge clk);

        // Single pass
        load(4, 8);
        step(SRK_CMD_START, 0, 0, 1'b1);
        chk("t1_shf", pif.shf_h, 4);
        chk("t1_mask", pif.mask_len_h, 8);
        chk("t1_last", pif.pass_last_h, 1);
        step(SRK_CMD_NOP, 0, 0, 1'b1);
        chk("t1_busy_drop", busy_h, 0);
        chk("t1_sta", sta_h, 3'b000);

        // Spanning, back-to-back
        load(28, 8);
        step(SRK_CMD_START, 0, 0, 1'b1);
        chk("t2_p0_shf", pif.shf_h, 28);
        chk("t2_p0_mask", pif.mask_len_h, 4);
        chk("t2_p0_last", pif.pass_last_h, 0);
        step(SRK_CMD_NOP, 0, 0, 1'b1);
        chk("t2_p1_shf", pif.shf_h, 4);
        chk("t2_p1_mask", pif.mask_len_h, 4);
        chk("t2_p1_last", pif.pass_last_h, 1);
        step(SRK_CMD_NOP, 0, 0, 1'b1);
        chk("t2_idle", busy_h, 0);
        chk("t2_sta0", sta_h[0], 1);

        // Stall in P0 with a load attempted meanwhile
        step(SRK_CMD_START, 0, 0, 1'b0);
        step(SRK_CMD_LD_POS, 5, 0, 1'b0);
        step(SRK_CMD_NOP, 0, 0, 1'b0);
        step(SRK_CMD_NOP, 0, 0, 1'b0);
        chk("t3_vld_held", pif.pass_vld_h, 1);
        chk("t3_shf_held", pif.shf_h, 28);
        chk("t3_mask_held", pif.mask_len_h, 4);
        step(SRK_CMD_NOP, 0, 0, 1'b1);
        step(SRK_CMD_NOP, 0, 0, 1'b1);
        rd("t3_rd_pos", SRK_CMD_RD_POS, 28);

        // Reserved size, then zero size
        step(SRK_CMD_LD_SIZ, 33, 0, 1'b1);
        step(SRK_CMD_START, 0, 0, 1'b1);
        chk("t4_rsv", rsv_err_h, 1);
        chk("t4_novld", pif.pass_vld_h, 0);
        step(SRK_CMD_LD_SIZ, 0, 0, 1'b1);
        chk("t4_rsv_clr", rsv_err_h, 0);
        step(SRK_CMD_START, 0, 0, 1'b1);
        chk("t4_sizzero", sta_h[1], 1);
        chk("t4_novld2", pif.pass_vld_h, 0);

        // MSS load and readback
        step(SRK_CMD_LD_POS_MSS, 0, 32'h0001_0000, 1'b1);
        rd("t5_mss16", SRK_CMD_RD_POS, 16);
        chk("t5_sta2_lo", sta_h[2], 0);
        step(SRK_CMD_LD_POS_MSS, 0, 32'h8000_0001, 1'b1);
        rd("t5_mss31", SRK_CMD_RD_POS, 31);
        step(SRK_CMD_LD_POS_MSS, 0, 0, 1'b1);
        rd("t5_mss0", SRK_CMD_RD_POS, 0);
        chk("t5_sta2_hi", sta_h[2], 1);
        rd("t5_nop", SRK_CMD_NOP, 64'hFFFF_FFFF);
        rd("t5_rd_siz", SRK_CMD_RD_SIZ, 0);

        // Boundary table with a one-cycle stall before acceptance
        for (int i = 0; i < 8; i++) begin
            load(tbl_pos[i], tbl_siz[i]);
            step(SRK_CMD_START, 0, 0, 1'b0);
            step(SRK_CMD_NOP, 0, 0, 1'b0);
            for (int k = 0; k < 3; k++) step(SRK_CMD_NOP, 0, 0, 1'b1);
        end

        // Abort in P1
        load(28, 8);
        step(SRK_CMD_START, 0, 0, 1'b1);
        step(SRK_CMD_NOP, 0, 0, 1'b1);
        chk("t6_in_p1", pif.pass_last_h, 1);
        step(SRK_CMD_ABORT, 0, 0, 1'b0);
        chk("t6_abort_vld", pif.pass_vld_h, 0);
        chk("t6_abort_busy", busy_h, 0);
        rd("t6_pos_kept", SRK_CMD_RD_POS, 28);

        // Reset while in P0
        step(SRK_CMD_START, 0, 0, 1'b0);
        #2 rst_l = 1'b0;
        #1;
        chk("t7_vld", pif.pass_vld_h, 0);
        chk("t7_shf", pif.shf_h, 0);
        chk("t7_mask", pif.mask_len_h, 0);
        chk("t7_last", pif.pass_last_h, 0);
        chk("t7_busy", busy_h, 0);
        chk("t7_sta", sta_h, 0);
        step(SRK_CMD_NOP, 0, 0, 1'b1);
        #2 rst_l = 1'b1;
        @(negedge clk);
        rd("t7_pos", SRK_CMD_RD_POS, 0);
        rd("t7_siz", SRK_CMD_RD_SIZ, 0);
        step(SRK_CMD_NOP, 0, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/srk_field_seq.md
Name: srk_field_seq

Overview:
- Parametrised successor to the shift/rotate-count control block. Holds field position (POS) and field size (SIZ) registers for variable-length bit-field operations.
- Sequences one or two datapath passes when a field crosses a word boundary. Each pass supplies a rotator shift count and a mask length over a valid/ready handshake.
- Sits beside the rotator: loads come from WBUS and SBUS, readback goes onto SBUS.
- Adds a parametrised most-significant-set (MSS) encoder and reserved-operand detection.

Parameters:
- DW, 32, datapath word width in bits; power of two, at least 8.
- SW, $clog2(DW), shift-count width.
- PW, $clog2(DW)+1, width of the POS, SIZ and mask-length fields.

Ports:
- qd_clk_l  in  1  block clock; all registers update on its rising edge.
- rst_l  in  1  reset, asynchronous, active-low.
- cmd_h  in  3  command: 0 NOP, 1 LD_POS, 2 LD_SIZ, 3 LD_POS_MSS, 4 START, 5 ABORT, 6 RD_POS, 7 RD_SIZ.
- wbus_h  in  DW  load source for LD_POS and LD_SIZ; low PW bits are used.
- sbus_h  in  DW  MSS encoder source.
- sbus_out_h  out  DW  readback value, combinational.
- pass_vld_h  out  1  pass descriptor valid.
- pass_rdy_h  in  1  datapath accepts the pass.
- shf_h  out  SW  rotate-right count for the current pass.
- mask_len_h  out  PW  number of field bits in the current pass, 1..DW.
- pass_last_h  out  1  current pass is the final pass.
- busy_h  out  1  sequencer not idle.
- sta_h  out  3  status {mss_none, siz_zero, spans}.
- rsv_err_h  out  1  sticky reserved-operand flag.

Behaviour:
- Reset (asynchronous, rst_l low):
  - POS=0, SIZ=0, state IDLE.
  - pass_vld_h=0, shf_h=0, mask_len_h=0, pass_last_h=0, busy_h=0, sta_h=0, rsv_err_h=0.
  - Reset in the middle of a sequence abandons it with no further passes.
- Derived values:
  - off = POS[SW-1:0].
  - end = off + SIZ, computed at PW+1 bits.
  - spans = (end > DW).
- Loads (accepted in IDLE only; ignored while busy_h=1):
  - LD_POS: POS <= wbus_h[PW-1:0].
  - LD_SIZ: SIZ <= wbus_h[PW-1:0]; clears rsv_err_h.
  - LD_POS_MSS: POS <= index of the most significant set bit of sbus_h; sta_h[2] <= 0.
  - LD_POS_MSS with sbus_h==0: POS <= 0; sta_h[2] <= 1.
- Readback (combinational, any state):
  - RD_POS: sbus_out_h = POS zero-extended to DW.
  - RD_SIZ: sbus_out_h = SIZ zero-extended to DW.
  - Any other command: sbus_out_h = all ones.
- START in IDLE (one-cycle evaluation; outputs registered):
  - SIZ > DW: rsv_err_h <= 1; remain IDLE; no pass issued.
  - SIZ == 0: sta_h[1] <= 1; remain IDLE; no pass issued.
  - Otherwise: sta_h[1:0] <= {0, spans}; go to P0 with pass_vld_h=1 in the next cycle.
- START while busy is ignored.
- State P0 outputs:
  - shf_h = off.
  - mask_len_h = spans ? DW-off : SIZ.
  - pass_last_h = ~spans.
- P0 exit on pass_vld_h & pass_rdy_h:
  - spans=1: go to P1.
  - spans=0: go to IDLE, with pass_vld_h=0 in the next cycle.
- State P1 outputs:
  - shf_h = (DW-off) mod DW.
  - mask_len_h = SIZ-(DW-off).
  - pass_last_h = 1.
- P1 exit on handshake: go to IDLE.
- Handshake stability:
  - While pass_vld_h=1 and pass_rdy_h=0, shf_h, mask_len_h and pass_last_h hold stable.
  - Back-to-back handshakes are allowed: P0 accept and P1 present occur in consecutive cycles.
- ABORT (any state): go to IDLE next cycle with pass_vld_h=0. POS, SIZ and sta_h are retained.
- busy_h = (state != IDLE).
- Outside P0/P1, shf_h and mask_len_h hold their last values.
- Sample boundaries: off=0 with SIZ=DW is a single pass (shf 0, mask DW). An end exactly equal to DW is not spanning.

Decomposition:
- Shared package srk_pkg:
  - Command encodings (SRK_CMD_*).
  - State enum {IDLE, P0, P1}.
  - Status bit indices.
- Sub-module srk_mss_enc: parametrised (DW) priority encoder with outputs idx[SW-1:0] and none. It is reused by later normaliser blocks.

Test Plan:
- DW=32, LD_POS 4, LD_SIZ 8, START, rdy=1 -> one pass: shf=4, mask=8, last=1. busy drops the cycle after the handshake. sta=000.
- LD_POS 28, LD_SIZ 8, START -> P0 shf=28 mask=4 last=0, then P1 shf=4 mask=4 last=1. sta[0]=1.
- Hold rdy=0 for 3 cycles in P0 (POS 28, SIZ 8) -> descriptors stable, vld stays 1. LD_POS issued during the stall is ignored (RD_POS returns 28).
- LD_SIZ 33, START -> rsv_err=1, no vld. A following LD_SIZ 0, START -> rsv_err=0, sta[1]=1, no vld.
- LD_POS_MSS with sbus=0x00010000 -> RD_POS returns 16, sta[2]=0. LD_POS_MSS with sbus=0 -> RD_POS returns 0, sta[2]=1. NOP -> sbus_out=0xFFFFFFFF.
- Spanning case with ABORT asserted in P1 -> vld=0 next cycle, IDLE. Repeat the sequence with rst_l low in P0 -> all outputs zero immediately; POS and SIZ read back 0.
